sys_cmd_ctrl: RTL and testbench

//  Command sequencer between the UART RX byte stream, the register file, the ALU and the TX FIFO.

---
 rtl/sys_cmd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: byte-command sequencer between UART RX, register file, ALU and TX FIFO.
// Ports:
//   CLK, RST (async, active low)
//   RX_P_DATA/RX_D_VLD          received command/operand bytes
//   RdData/RdData_VLD           register-file read return
//   ALU_OUT/ALU_OUT_VLD         ALU result return
//   FIFO_FULL                   TX FIFO back-pressure
//   WrEn/RdEn/regfile_operation_flag/Address/WrData   register-file access
//   ALU_EN/ALU_FUN/CLK_EN       ALU control
//   TX_P_DATA/TX_D_VLD          TX FIFO push
module sys_cmd_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int ALU_W  = 16,
  parameter int FUN_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_VLD,
  input  logic [ALU_W-1:0]  ALU_OUT,
  input  logic              ALU_OUT_VLD,
  input  logic              FIFO_FULL,
  output logic              WrEn,
  output logic              RdEn,
  output logic              regfile_operation_flag,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WrData,
  output logic              ALU_EN,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              CLK_EN,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD
);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUNC, ALU_WAIT, SEND_LSB, SEND_MSB
  } state_t;
  localparam logic [DATA_W-1:0] CMD_WR = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_OP = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_FN = DATA_W'(8'hDD);
  state_t            state, state_nx;
  logic [ALU_W-1:0]  res, res_nx;
  logic              two, two_nx;
  logic              wr_en_nx, rd_en_nx, alu_en_nx, clk_en_nx, tx_vld_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wr_data_nx, tx_data_nx;
  logic [FUN_W-1:0]  alu_fun_nx;
  // All outputs are registered: the comb block computes their next values.
  // Pulse outputs default low, held outputs default to their current value.
  always_comb begin
    state_nx   = state;
    res_nx     = res;
    two_nx     = two;
    wr_en_nx   = 1'b0;
    tx_vld_nx  = 1'b0;
    rd_en_nx   = RdEn;
    alu_en_nx  = ALU_EN;
    clk_en_nx  = CLK_EN;
    addr_nx    = Address;
    wr_data_nx = WrData;
    alu_fun_nx = ALU_FUN;
    tx_data_nx = TX_P_DATA;
    case (state)
      IDLE: if (RX_D_VLD)
        state_nx = (RX_P_DATA == CMD_WR) ? WR_ADDR :
                   (RX_P_DATA == CMD_RD) ? RD_ADDR :
                   (RX_P_DATA == CMD_OP) ? OP_A :
                   (RX_P_DATA == CMD_FN) ? ALU_FUNC : IDLE;
      WR_ADDR: if (RX_D_VLD) begin
        addr_nx  = RX_P_DATA[ADDR_W-1:0];
        state_nx = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wr_data_nx = RX_P_DATA;
        wr_en_nx   = 1'b1;
        state_nx   = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_nx  = RX_P_DATA[ADDR_W-1:0];
        rd_en_nx = 1'b1;
        state_nx = RD_WAIT;
      end
      RD_WAIT: if (RdData_VLD) begin
        rd_en_nx = 1'b0;
        res_nx   = ALU_W'(RdData);
        two_nx   = 1'b0;
        state_nx = SEND_LSB;
      end
      OP_A: if (RX_D_VLD) begin
        addr_nx    = '0;
        wr_data_nx = RX_P_DATA;
        wr_en_nx   = 1'b1;
        state_nx   = OP_B;
      end
      OP_B: if (RX_D_VLD) begin
        addr_nx    = ADDR_W'(1);
        wr_data_nx = RX_P_DATA;
        wr_en_nx   = 1'b1;
        state_nx   = ALU_FUNC;
      end
      ALU_FUNC: if (RX_D_VLD) begin
        alu_fun_nx = RX_P_DATA[FUN_W-1:0];
        alu_en_nx  = 1'b1;
        clk_en_nx  = 1'b1;
        state_nx   = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        res_nx    = ALU_OUT;
        two_nx    = 1'b1;
        alu_en_nx = 1'b0;
        clk_en_nx = 1'b0;
        state_nx  = SEND_LSB;
      end
      SEND_LSB: if (!FIFO_FULL) begin
        tx_data_nx = res[DATA_W-1:0];
        tx_vld_nx  = 1'b1;
        state_nx   = two ? SEND_MSB : IDLE;
      end
      SEND_MSB: if (!FIFO_FULL) begin
        tx_data_nx = res[ALU_W-1 -: DATA_W];
        tx_vld_nx  = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state                  <= IDLE;
      res                    <= '0;
      two                    <= 1'b0;
      WrEn                   <= 1'b0;
      RdEn                   <= 1'b0;
      regfile_operation_flag <= 1'b0;
      Address                <= '0;
      WrData                 <= '0;
      ALU_EN                 <= 1'b0;
      ALU_FUN                <= '0;
      CLK_EN                 <= 1'b0;
      TX_P_DATA              <= '0;
      TX_D_VLD               <= 1'b0;
    end else begin
      state                  <= state_nx;
      res                    <= res_nx;
      two                    <= two_nx;
      WrEn                   <= wr_en_nx;
      RdEn                   <= rd_en_nx;
      regfile_operation_flag <= wr_en_nx | rd_en_nx;
      Address                <= addr_nx;
      WrData                 <= wr_data_nx;
      ALU_EN                 <= alu_en_nx;
      ALU_FUN                <= alu_fun_nx;
      CLK_EN                 <= clk_en_nx;
      TX_P_DATA              <= tx_data_nx;
      TX_D_VLD               <= tx_vld_nx;
    end
  end
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb_sys_cmd_ctrl: vector table, corner sequences and random commands against a command-level model.
module tb_sys_cmd_ctrl;
  logic        CLK = 1'b0, RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        WrEn, RdEn, regfile_operation_flag, ALU_EN, CLK_EN, TX_D_VLD;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, TX_P_DATA;
  logic [29:0] outs;
  assign outs = {WrEn, RdEn, regfile_operation_flag, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD};

  sys_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_VLD(RdData_VLD), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_FULL(FIFO_FULL), .WrEn(WrEn), .RdEn(RdEn), .regfile_operation_flag(regfile_operation_flag),
    .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  b [4];
    int          nw;
    logic [11:0] w [2];
    int          nt;
    logic [7:0]  t [2];
  } vec_t;
  vec_t tab [12];

  int checks = 0, errors = 0, viol = 0, rd_cyc = 0;
  int rd_lat = 1, alu_lat = 1, rd_cnt = 0, alu_cnt = 0, wi = 0, ti = 0, cn = 0;
  logic [11:0] wq [$], ew [$];
  logic [7:0]  tq [$], et [$];
  logic [7:0]  rf [16] = '{default: 8'h00};
  logic [7:0]  mreg [16] = '{default: 8'h00};
  logic [7:0]  cb [4];

  function automatic logic [15:0] alu(logic [7:0] a, logic [7:0] b, logic [3:0] f);
    case (f)
      4'd0: return 16'(a) + 16'(b);
      4'd1: return 16'(a) - 16'(b);
      4'd2: return 16'(a) * 16'(b);
      4'd3: return {8'h00, a & b};
      4'd4: return {8'h00, a | b};
      4'd5: return {8'h00, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  function automatic int cmd_len(logic [7:0] c);
    return c == 8'hAA ? 3 : c == 8'hBB ? 2 : c == 8'hCC ? 4 : c == 8'hDD ? 2 : 1;
  endfunction

  // Register file and ALU stand-ins plus bus monitor, all in one process so their order is fixed.
  always @(negedge CLK) begin
    RdData_VLD  = 1'b0;
    ALU_OUT_VLD = 1'b0;
    if (!RST) begin
      rd_cnt  = 0;
      alu_cnt = 0;
    end else begin
      if (WrEn) begin
        wq.push_back({Address, WrData});
        rf[Address] = WrData;
      end
      if (TX_D_VLD) begin
        if (FIFO_FULL) viol++;
        else tq.push_back(TX_P_DATA);
      end
      if ((WrEn && RdEn) || (regfile_operation_flag != (WrEn || RdEn)) || (ALU_EN && !CLK_EN)) viol++;
      if (RdEn) begin
        rd_cyc++;
        if (rd_cnt == rd_lat) begin
          RdData     = rf[Address];
          RdData_VLD = 1'b1;
          rd_cnt     = 0;
        end else rd_cnt++;
      end else rd_cnt = 0;
      if (ALU_EN) begin
        if (alu_cnt == alu_lat) begin
          ALU_OUT     = alu(rf[0], rf[1], ALU_FUN);
          ALU_OUT_VLD = 1'b1;
          alu_cnt     = 0;
        end else alu_cnt++;
      end else alu_cnt = 0;
    end
  end

  task automatic tick;
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Command-level model: what each framed command must write and send.
  task automatic model;
    logic [15:0] r;
    ew.delete();
    et.delete();
    case (cb[0])
      8'hAA: begin
        ew.push_back({cb[1][3:0], cb[2]});
        mreg[cb[1][3:0]] = cb[2];
      end
      8'hBB: et.push_back(mreg[cb[1][3:0]]);
      8'hCC: begin
        ew.push_back({4'h0, cb[1]});
        ew.push_back({4'h1, cb[2]});
        mreg[0] = cb[1];
        mreg[1] = cb[2];
        r = alu(mreg[0], mreg[1], cb[3][3:0]);
        et.push_back(r[7:0]);
        et.push_back(r[15:8]);
      end
      8'hDD: begin
        r = alu(mreg[0], mreg[1], cb[1][3:0]);
        et.push_back(r[7:0]);
        et.push_back(r[15:8]);
      end
      default: ;
    endcase
  endtask

  task automatic send_byte(logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic settle(int n, bit rnd);
    for (int k = 0; k < 300 && tq.size() - ti < n; k++) begin
      if (rnd) FIFO_FULL = ($urandom_range(0, 2) == 0);
      tick;
    end
    FIFO_FULL = 1'b0;
    repeat (4) tick;
  endtask

  task automatic compare(string name);
    chk($sformatf("%s wr_count", name), 32'(wq.size() - wi), 32'(ew.size()));
    foreach (ew[k]) if (wi + k < wq.size()) chk($sformatf("%s wr%0d", name, k), 32'(wq[wi+k]), 32'(ew[k]));
    wi = wq.size();
    chk($sformatf("%s tx_count", name), 32'(tq.size() - ti), 32'(et.size()));
    foreach (et[k]) if (ti + k < tq.size()) chk($sformatf("%s tx%0d", name, k), 32'(tq[ti+k]), 32'(et[k]));
    ti = tq.size();
  endtask

  task automatic exec(string name, bit rnd);
    for (int i = 0; i < cn; i++) begin
      send_byte(cb[i]);
      if (rnd) repeat ($urandom_range(0, 2)) tick;
    end
    settle(et.size(), rnd);
    compare(name);
  endtask

  task automatic run(string name, bit rnd);
    cn = cmd_len(cb[0]);
    model();
    exec(name, rnd);
  endtask

  task automatic set_vec(int i, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3,
                         int nw, logic [11:0] w0, logic [11:0] w1, int nt, logic [7:0] t0, logic [7:0] t1);
    tab[i].b[0] = b0; tab[i].b[1] = b1; tab[i].b[2] = b2; tab[i].b[3] = b3;
    tab[i].nw = nw; tab[i].w[0] = w0; tab[i].w[1] = w1;
    tab[i].nt = nt; tab[i].t[0] = t0; tab[i].t[1] = t1;
  endtask

  task automatic load(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    cb[0] = b0; cb[1] = b1; cb[2] = b2; cb[3] = b3;
  endtask

  initial begin
    int r0;
    logic [7:0] b;
    set_vec(0,  8'hAA, 8'h05, 8'h3C, 8'h00, 1, 12'h53C, 12'h000, 0, 8'h00, 8'h00);
    set_vec(1,  8'hBB, 8'h05, 8'h00, 8'h00, 0, 12'h000, 12'h000, 1, 8'h3C, 8'h00);
    set_vec(2,  8'h55, 8'h00, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 8'h00, 8'h00);
    set_vec(3,  8'hAA, 8'h01, 8'h77, 8'h00, 1, 12'h177, 12'h000, 0, 8'h00, 8'h00);
    set_vec(4,  8'hAA, 8'h02, 8'h21, 8'h00, 1, 12'h221, 12'h000, 0, 8'h00, 8'h00);
    set_vec(5,  8'hBB, 8'hF2, 8'h00, 8'h00, 0, 12'h000, 12'h000, 1, 8'h21, 8'h00);
    set_vec(6,  8'hCC, 8'h0A, 8'h03, 8'h00, 2, 12'h00A, 12'h103, 2, 8'h0D, 8'h00);
    set_vec(7,  8'hDD, 8'h01, 8'h00, 8'h00, 0, 12'h000, 12'h000, 2, 8'h07, 8'h00);
    set_vec(8,  8'hCC, 8'hFF, 8'h02, 8'h02, 2, 12'h0FF, 12'h102, 2, 8'hFE, 8'h01);
    set_vec(9,  8'hCC, 8'h80, 8'h90, 8'h01, 2, 12'h080, 12'h190, 2, 8'hF0, 8'hFF);
    set_vec(10, 8'hDD, 8'h17, 8'h00, 8'h00, 0, 12'h000, 12'h000, 2, 8'h90, 8'h80);
    set_vec(11, 8'hBB, 8'h01, 8'h00, 8'h00, 0, 12'h000, 12'h000, 1, 8'h90, 8'h00);

    repeat (3) tick;
    chk("reset_outputs", 32'(outs), 32'h0);
    RST = 1'b1;
    tick;

    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 4; j++) cb[j] = tab[i].b[j];
      cn = cmd_len(cb[0]);
      model();
      ew.delete();
      et.delete();
      for (int j = 0; j < tab[i].nw; j++) ew.push_back(tab[i].w[j]);
      for (int j = 0; j < tab[i].nt; j++) et.push_back(tab[i].t[j]);
      exec($sformatf("vec%0d", i), 1'b0);
    end

    load(8'hBB, 8'h02, 8'h00, 8'h00);
    cn = 2;
    model();
    r0 = rd_cyc;
    send_byte(8'hBB);
    send_byte(8'h02);
    send_byte(8'hAA);
    settle(et.size(), 1'b0);
    compare("rd_stray");
    chk("rd_en_cycles", 32'(rd_cyc - r0), 32'd2);

    load(8'hCC, 8'h0A, 8'h03, 8'h00);
    run("alu_cc", 1'b0);
    chk("alu_cc_fun", 32'(ALU_FUN), 32'h0);
    chk("alu_cc_idle_en", 32'({CLK_EN, ALU_EN}), 32'h0);

    load(8'hDD, 8'h02, 8'h00, 8'h00);
    cn = 2;
    model();
    FIFO_FULL = 1'b1;
    send_byte(8'hDD);
    send_byte(8'h02);
    for (int k = 0; k < 50 && !ALU_OUT_VLD; k++) tick;
    chk("alu_vld_seen", 32'(ALU_OUT_VLD), 32'h1);
    chk("alu_hold", 32'({ALU_EN, CLK_EN, ALU_FUN}), 32'h32);
    repeat (5) tick;
    chk("no_push_when_full", 32'(tq.size() - ti), 32'h0);
    chk("alu_released", 32'({ALU_EN, CLK_EN}), 32'h0);
    FIFO_FULL = 1'b0;
    tick;
    chk("first_push", 32'({TX_D_VLD, TX_P_DATA}), 32'h11E);
    settle(et.size(), 1'b0);
    compare("dd_full");

    send_byte(8'hCC);
    send_byte(8'h0A);
    tick;
    tick;
    mreg[0] = 8'h0A;
    ew.delete();
    et.delete();
    ew.push_back(12'h00A);
    compare("rst_partial");
    RST = 1'b0;
    #1;
    chk("rst_async_outputs", 32'(outs), 32'h0);
    tick;
    RST = 1'b1;
    tick;
    load(8'hBB, 8'h00, 8'h00, 8'h00);
    run("rd_after_rst0", 1'b0);
    load(8'hBB, 8'h01, 8'h00, 8'h00);
    run("rd_after_rst1", 1'b0);

    for (int i = 0; i < 40; i++) begin
      rd_lat  = $urandom_range(0, 3);
      alu_lat = $urandom_range(0, 4);
      b = 8'($urandom);
      if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'h11;
      case ($urandom_range(0, 4))
        0: cb[0] = 8'hAA;
        1: cb[0] = 8'hBB;
        2: cb[0] = 8'hCC;
        3: cb[0] = 8'hDD;
        default: cb[0] = b;
      endcase
      for (int j = 1; j < 4; j++) cb[j] = 8'($urandom);
      run($sformatf("rnd%0d_%h", i, cb[0]), 1'b1);
    end

    chk("protocol_violations", 32'(viol), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
